// File: rtl/tftp_request_decode_pkg.sv
// Shared opcodes, error codes, parser states and the default name/address
// tables for the TFTP RRQ/WRQ request decoder.
package tftp_request_decode_pkg;

    localparam logic [15:0] OP_RRQ    = 16'd1;
    localparam logic [15:0] OP_WRQ    = 16'd2;
    localparam logic [15:0] TFTP_PORT = 16'd69;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_OPCODE = 3'd1,
        ERR_NAME_LONG  = 3'd2,
        ERR_NOT_FOUND  = 3'd3,
        ERR_BAD_MODE   = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP_LO,
        ST_NAME,
        ST_MODE,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int                    MODE_LEN   = 5;
    localparam logic [8*MODE_LEN-1:0] MODE_OCTET = "octet";

    // Entry 0 sits at the MSB end; each entry is 20 bytes, first character first, NUL-padded.
    localparam logic [4*20*8-1:0] DEFAULT_NAMES = {
        "boot.bin", 96'h0,
        "test.txt", 96'h0,
        "config.cfg", 80'h0,
        "readme", 112'h0
    };
    localparam logic [4*16-1:0] DEFAULT_ADDRS = {16'h0000, 16'h0400, 16'h0800, 16'h0C00};

    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
    endfunction

    // Expected mode byte at position i; the terminating NUL follows the last letter.
    function automatic logic [7:0] mode_char(input int i);
        if (i < MODE_LEN) begin
            return MODE_OCTET[8*(MODE_LEN-1-i) +: 8];
        end else begin
            return 8'h00;
        end
    endfunction

endpackage

// File: rtl/tftp_request_decode_filename_rom.sv
// Constant filename table and file base-address table. Returns byte idx of
// every name in parallel; positions at or beyond MAX_NAME_LEN read as NUL.
module tftp_request_decode_filename_rom #(
    parameter int NUM_FILES    = 4,
    parameter int MAX_NAME_LEN = 20,
    parameter int ADDR_W       = 16,
    parameter int IDX_W        = 5,
    parameter logic [NUM_FILES*MAX_NAME_LEN*8-1:0] NAME_TABLE = '0,
    parameter logic [NUM_FILES*ADDR_W-1:0]         ADDR_TABLE = '0
) (
    input  logic [IDX_W-1:0]                  idx,
    output logic [NUM_FILES-1:0][7:0]         name_bytes,
    output logic [NUM_FILES-1:0][ADDR_W-1:0]  file_addr
);

    localparam int TBITS = NUM_FILES * MAX_NAME_LEN * 8;

    // NOTE: the tables are constants, so there is nothing to reset here.
    always_comb begin
        for (int k = 0; k < NUM_FILES; k++) begin
            name_bytes[k] = 8'h00;
            if (int'(idx) < MAX_NAME_LEN) begin
                name_bytes[k] = NAME_TABLE[TBITS - 8 - (k * MAX_NAME_LEN + int'(idx)) * 8 +: 8];
            end
            file_addr[k] = ADDR_TABLE[(NUM_FILES - 1 - k) * ADDR_W +: ADDR_W];
        end
    end

endmodule

// File: rtl/tftp_request_decode.sv
// TFTP RRQ/WRQ payload parser: opcode, filename lookup in a constant table,
// "octet" mode check; reports a matched file or a rejection code.
module tftp_request_decode
    import tftp_request_decode_pkg::*;
#(
    parameter int          NUM_FILES    = 4,
    parameter int          MAX_NAME_LEN = 20,
    parameter int          ADDR_W       = 16,
    parameter logic [15:0] SERVER_PORT  = TFTP_PORT,
    parameter logic [NUM_FILES*MAX_NAME_LEN*8-1:0] NAME_TABLE = DEFAULT_NAMES,
    parameter logic [NUM_FILES*ADDR_W-1:0]         ADDR_TABLE = DEFAULT_ADDRS,
    parameter int          FILE_IDX_W   = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sof,
    input  logic [7:0]            eth_data,
    input  logic [15:0]           dest_port,
    output logic                  valid,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic [ADDR_W-1:0]     mem_location,
    output logic [FILE_IDX_W-1:0] file_index,
    output logic                  is_write,
    output logic                  valid_port,
    output logic                  busy
);

    // One counter walks both the name and the mode string.
    localparam int IDX_W = $clog2(((MAX_NAME_LEN > MODE_LEN) ? MAX_NAME_LEN : MODE_LEN) + 1);

    state_e                 state_q, state_d;
    err_code_e              err_q, err_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_FILES-1:0]   match_q, match_d, match_next;
    logic [7:0]             op_hi_q, op_hi_d;
    logic                   valid_d, error_d, wr_d, vp_d;
    logic [ADDR_W-1:0]      mem_d, first_addr;
    logic [FILE_IDX_W-1:0]  fi_d, first_fi;
    logic [15:0]            opcode;

    logic [NUM_FILES-1:0][7:0]        name_bytes;
    logic [NUM_FILES-1:0][ADDR_W-1:0] file_addr;

    tftp_request_decode_filename_rom #(
        .NUM_FILES    (NUM_FILES),
        .MAX_NAME_LEN (MAX_NAME_LEN),
        .ADDR_W       (ADDR_W),
        .IDX_W        (IDX_W),
        .NAME_TABLE   (NAME_TABLE),
        .ADDR_TABLE   (ADDR_TABLE)
    ) u_rom (
        .idx        (idx_q),
        .name_bytes (name_bytes),
        .file_addr  (file_addr)
    );

    assign opcode = {op_hi_q, eth_data};

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        match_d    = match_q;
        op_hi_d    = op_hi_q;
        err_d      = err_q;
        mem_d      = mem_location;
        fi_d       = file_index;
        wr_d       = is_write;
        vp_d       = valid_port;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        match_next = match_q;
        first_fi   = '0;
        first_addr = '0;

        for (int k = 0; k < NUM_FILES; k++) begin
            match_next[k] = match_q[k] && (name_bytes[k] == eth_data);
        end
        // Descending scan leaves the lowest surviving entry selected.
        for (int k = NUM_FILES - 1; k >= 0; k--) begin
            if (match_next[k]) begin
                first_fi   = FILE_IDX_W'(k);
                first_addr = file_addr[k];
            end
        end

        if (en && sof) begin
            vp_d = (dest_port == SERVER_PORT);
            if (dest_port == SERVER_PORT) begin
                state_d = ST_OP_LO;
                op_hi_d = eth_data;
                err_d   = ERR_NONE;
                wr_d    = 1'b0;
                fi_d    = '0;
                mem_d   = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (en) begin
            case (state_q)
                ST_OP_LO: begin
                    if (opcode == OP_RRQ || opcode == OP_WRQ) begin
                        wr_d    = (opcode == OP_WRQ);
                        state_d = ST_NAME;
                        idx_d   = '0;
                        match_d = '1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        err_d   = ERR_BAD_OPCODE;
                    end
                end
                ST_NAME: begin
                    // A NUL only survives where the table entry also ends here.
                    if (eth_data == 8'h00) begin
                        if (|match_next) begin
                            state_d = ST_MODE;
                            idx_d   = '0;
                            fi_d    = first_fi;
                            mem_d   = first_addr;
                        end else begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                            err_d   = ERR_NOT_FOUND;
                        end
                    end else if (idx_q == IDX_W'(MAX_NAME_LEN)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        err_d   = ERR_NAME_LONG;
                    end else begin
                        match_d = match_next;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                ST_MODE: begin
                    if (fold_case(eth_data) != mode_char(int'(idx_q))) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        err_d   = ERR_BAD_MODE;
                    end else if (idx_q == IDX_W'(MODE_LEN)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            idx_q        <= '0;
            match_q      <= '1;
            op_hi_q      <= '0;
            valid        <= 1'b0;
            error        <= 1'b0;
            mem_location <= '0;
            file_index   <= '0;
            is_write     <= 1'b0;
            valid_port   <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            match_q      <= match_d;
            op_hi_q      <= op_hi_d;
            valid        <= valid_d;
            error        <= error_d;
            mem_location <= mem_d;
            file_index   <= fi_d;
            is_write     <= wr_d;
            valid_port   <= vp_d;
        end
    end

    assign err_code = err_q;
    assign busy     = (state_q == ST_OP_LO) || (state_q == ST_NAME) || (state_q == ST_MODE);

endmodule
